// File: rtl/evt_pkt_extractor_pkg.sv
// Shared event-packet format definitions, common to the inserter and this extractor.
package evt_pkt_extractor_pkg;

  localparam logic [7:0]  IO_QUEUE_STAGE_NUM    = 8'hFF;
  localparam logic [15:0] EVT_ETHERTYPE_DFLT     = 16'h88B5;
  localparam int unsigned NUM_WORDS_IN_HDR_DFLT  = 7;
  localparam int unsigned NUM_WORDS_PAYLOAD_DFLT = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CAPTURE = 3'd1;
  localparam logic [2:0] ST_REPLAY  = 3'd2;
  localparam logic [2:0] ST_PASS    = 3'd3;
  localparam logic [2:0] ST_EVT_HDR = 3'd4;
  localparam logic [2:0] ST_EVT_PLD = 3'd5;
  localparam logic [2:0] ST_DROP    = 3'd6;

  // End-of-packet: any nonzero ctrl other than the module-header marker.
  function automatic logic is_eop(input logic [7:0] ctrl);
    return (ctrl != 8'h00) && (ctrl != IO_QUEUE_STAGE_NUM);
  endfunction

endpackage

// File: rtl/fallthrough_small_fifo_old.sv
// Small first-word-fallthrough FIFO: dout shows the head word whenever empty is low.
module fallthrough_small_fifo_old #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  input  logic             reset,
  input  logic             clk
);

  localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [MAX_DEPTH_BITS:0]   depth;
  logic                      wr_ok, rd_ok;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign full  = (depth == (MAX_DEPTH_BITS+1)'(DEPTH));
  assign empty = (depth == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      depth  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   depth <= depth + 1'b1;
        2'b01:   depth <= depth - 1'b1;
        default: depth <= depth;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/evt_pkt_extractor.sv
// Strips event packets (by EtherType) from the bus into a payload FIFO;
// every other packet is forwarded unchanged and in order.
module evt_pkt_extractor
  import evt_pkt_extractor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned CTRL_WIDTH        = 8,
  parameter int unsigned WORD_WIDTH        = 64,
  parameter int unsigned NUM_WORDS_IN_HDR  = NUM_WORDS_IN_HDR_DFLT,
  parameter int unsigned NUM_WORDS_PAYLOAD = NUM_WORDS_PAYLOAD_DFLT,
  parameter logic [15:0] EVT_ETHERTYPE     = EVT_ETHERTYPE_DFLT,
  parameter int unsigned PLD_DEPTH_BITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [WORD_WIDTH-1:0] pld_fifo_dout,
  output logic                  pld_fifo_empty,
  input  logic                  pld_fifo_rd_en,
  output logic [31:0]           evt_pkt_cnt,
  output logic [31:0]           evt_err_cnt
);

  logic [DATA_WIDTH-1:0] in_fifo_data;
  logic [CTRL_WIDTH-1:0] in_fifo_ctrl;
  logic                  in_fifo_empty, in_fifo_full, in_fifo_rd_en;
  logic                  pld_fifo_full, pld_fifo_wr_en;
  logic                  head_eop;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] buf_data [3];
  logic [CTRL_WIDTH-1:0] buf_ctrl [3];
  logic [1:0]            cap_cnt, rep_cnt, buf_last;
  logic                  buf_eop;
  logic [7:0]            hdr_cnt, pld_cnt;

  fallthrough_small_fifo_old #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (3)
  ) input_fifo (
    .din   ({in_ctrl, in_data}),
    .wr_en (in_wr),
    .rd_en (in_fifo_rd_en),
    .dout  ({in_fifo_ctrl, in_fifo_data}),
    .full  (in_fifo_full),
    .empty (in_fifo_empty),
    .reset (reset),
    .clk   (clk)
  );

  fallthrough_small_fifo_old #(
    .WIDTH          (WORD_WIDTH),
    .MAX_DEPTH_BITS (PLD_DEPTH_BITS)
  ) pld_fifo (
    .din   (in_fifo_data),
    .wr_en (pld_fifo_wr_en),
    .rd_en (pld_fifo_rd_en),
    .dout  (pld_fifo_dout),
    .full  (pld_fifo_full),
    .empty (pld_fifo_empty),
    .reset (reset),
    .clk   (clk)
  );

  assign in_rdy   = !in_fifo_full;
  assign head_eop = is_eop(in_fifo_ctrl);

  always_comb begin
    in_fifo_rd_en  = 1'b0;
    pld_fifo_wr_en = 1'b0;
    out_wr         = 1'b0;
    out_data       = in_fifo_data;
    out_ctrl       = in_fifo_ctrl;
    case (state)
      ST_CAPTURE, ST_EVT_HDR, ST_DROP: in_fifo_rd_en = !in_fifo_empty;
      ST_REPLAY: begin
        out_data = buf_data[rep_cnt];
        out_ctrl = buf_ctrl[rep_cnt];
        out_wr   = out_rdy;
      end
      ST_PASS: begin
        out_wr        = out_rdy && !in_fifo_empty;
        in_fifo_rd_en = out_rdy && !in_fifo_empty;
      end
      ST_EVT_PLD: begin
        pld_fifo_wr_en = !in_fifo_empty && !pld_fifo_full;
        in_fifo_rd_en  = !in_fifo_empty && !pld_fifo_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cap_cnt     <= '0;
      rep_cnt     <= '0;
      buf_last    <= '0;
      buf_eop     <= 1'b0;
      hdr_cnt     <= '0;
      pld_cnt     <= '0;
      evt_pkt_cnt <= '0;
      evt_err_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!in_fifo_empty) begin
            state   <= ST_CAPTURE;
            cap_cnt <= '0;
          end
        end
        ST_CAPTURE: begin
          if (!in_fifo_empty) begin
            buf_data[cap_cnt] <= in_fifo_data;
            buf_ctrl[cap_cnt] <= in_fifo_ctrl;
            cap_cnt           <= cap_cnt + 2'd1;
            // A packet ending at word 2 is complete, so it is replayed even with the event EtherType.
            if (head_eop || cap_cnt == 2'd2) begin
              buf_last <= cap_cnt;
              buf_eop  <= head_eop;
              rep_cnt  <= '0;
              if (!head_eop && in_fifo_data[31:16] == EVT_ETHERTYPE) begin
                state   <= ST_EVT_HDR;
                hdr_cnt <= 8'd3;
              end else begin
                state <= ST_REPLAY;
              end
            end
          end
        end
        ST_REPLAY: begin
          if (out_rdy) begin
            rep_cnt <= rep_cnt + 2'd1;
            if (rep_cnt == buf_last) state <= buf_eop ? ST_IDLE : ST_PASS;
          end
        end
        ST_PASS: begin
          if (out_rdy && !in_fifo_empty && head_eop) state <= ST_IDLE;
        end
        ST_EVT_HDR: begin
          if (!in_fifo_empty) begin
            if (head_eop) begin
              evt_err_cnt <= evt_err_cnt + 32'd1;
              state       <= ST_IDLE;
            end else begin
              hdr_cnt <= hdr_cnt + 8'd1;
              if (hdr_cnt == 8'(NUM_WORDS_IN_HDR - 1)) begin
                state   <= ST_EVT_PLD;
                pld_cnt <= '0;
              end
            end
          end
        end
        ST_EVT_PLD: begin
          if (pld_fifo_wr_en) begin
            pld_cnt <= pld_cnt + 8'd1;
            if (head_eop) begin
              if (pld_cnt == 8'(NUM_WORDS_PAYLOAD - 1)) evt_pkt_cnt <= evt_pkt_cnt + 32'd1;
              else                                      evt_err_cnt <= evt_err_cnt + 32'd1;
              state <= ST_IDLE;
            end else if (pld_cnt == 8'(NUM_WORDS_PAYLOAD - 1)) begin
              evt_err_cnt <= evt_err_cnt + 32'd1;
              state       <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (!in_fifo_empty && head_eop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evt_pkt_extractor.sv
// Randomized scoreboard bench for evt_pkt_extractor with a packet-level reference model.
module tb_evt_pkt_extractor;

  typedef logic [71:0] word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic [63:0] pld_fifo_dout;
  logic        pld_fifo_empty;
  logic        pld_fifo_rd_en = 1'b0;
  logic [31:0] evt_pkt_cnt, evt_err_cnt;

  always #5 clk = ~clk;

  evt_pkt_extractor dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_ctrl        (in_ctrl),
    .in_wr          (in_wr),
    .in_rdy         (in_rdy),
    .out_data       (out_data),
    .out_ctrl       (out_ctrl),
    .out_wr         (out_wr),
    .out_rdy        (out_rdy),
    .pld_fifo_dout  (pld_fifo_dout),
    .pld_fifo_empty (pld_fifo_empty),
    .pld_fifo_rd_en (pld_fifo_rd_en),
    .evt_pkt_cnt    (evt_pkt_cnt),
    .evt_err_cnt    (evt_err_cnt)
  );

  word_t       tx_q[$];
  word_t       exp_out[$];
  logic [63:0] exp_pld[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned exp_pkt = 0;
  int unsigned exp_err = 0;
  int          rdy_mode = 0;   // 0: always ready, 1: random 50%
  int          pop_mode = 1;   // 0: only pop_once, 1: always, 2: every 4th cycle, 3: random
  bit          pop_once = 1'b0;
  bit          saw_stall = 1'b0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packet-level reference: decides the fate of a whole packet from its length and EtherType.
  task automatic ref_model(input word_t p[$]);
    int len;
    int np;
    bit is_evt;
    len    = p.size();
    is_evt = (len > 3) && (p[2][31:16] == 16'h88B5);
    if (!is_evt) begin
      foreach (p[i]) exp_out.push_back(p[i]);
    end else begin
      np = len - 7;
      if (np <= 0) exp_err++;
      else begin
        for (int i = 0; i < np && i < 8; i++) exp_pld.push_back(p[7+i][63:0]);
        if (np == 8) exp_pkt++;
        else         exp_err++;
      end
    end
  endtask

  task automatic send_pkt(input int len, input bit evt, input logic [63:0] pld_base,
                          input logic [7:0] eop_ctrl);
    word_t       p[$];
    logic [63:0] d;
    logic [7:0]  c;
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (i == 2) d[31:16] = evt ? 16'h88B5 : ($urandom_range(0, 1) ? 16'h0800 : 16'h86DD);
      if (evt && i >= 7) d = pld_base + 64'(i - 7);
      if (i == 0)            c = 8'hFF;
      else if (i == len - 1) c = (eop_ctrl != 8'h00) ? eop_ctrl : (8'h01 << $urandom_range(0, 6));
      else                   c = 8'h00;
      p.push_back({c, d});
    end
    ref_model(p);
    foreach (p[i]) tx_q.push_back(p[i]);
  endtask

  // Input driver: honours in_rdy, sampled away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_q.size() > 0 && in_rdy) begin
        {in_ctrl, in_data} = tx_q.pop_front();
        in_wr = 1'b1;
      end else begin
        in_wr = 1'b0;
      end
    end
  end

  // Monitor: drives out_rdy / pld_fifo_rd_en, then compares what the next edge will consume.
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      out_rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      case (pop_mode)
        0:       pop = pop_once;
        1:       pop = 1'b1;
        2:       pop = (cyc % 4 == 0);
        default: pop = 1'($urandom_range(0, 1));
      endcase
      pld_fifo_rd_en = pop;
      #1;
      if (!reset) begin
        if (out_wr) begin
          check("out_wr_needs_rdy", 72'(out_rdy), 72'(1));
          if (exp_out.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %h expected nothing", {out_ctrl, out_data});
          end else begin
            check("out_word", {out_ctrl, out_data}, exp_out.pop_front());
          end
        end
        if (pop && !pld_fifo_empty) begin
          pop_once = 1'b0;
          if (exp_pld.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pld: got %h expected nothing", pld_fifo_dout);
          end else begin
            check("pld_word", 72'(pld_fifo_dout), 72'(exp_pld.pop_front()));
          end
        end
        if (!in_rdy) saw_stall = 1'b1;
      end
      cyc++;
    end
  end

  task automatic wait_drain(input string name, input bit need_pld, input int max_cyc);
    int c;
    c = 0;
    while ((tx_q.size() != 0 || exp_out.size() != 0 || (need_pld && exp_pld.size() != 0))
           && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check(name, 72'(c < max_cyc), 72'(1));
    repeat (20) @(negedge clk);
  endtask

  task automatic check_cnts(input string name);
    #2;
    check({name, "_pkt_cnt"}, 72'(evt_pkt_cnt), 72'(exp_pkt));
    check({name, "_err_cnt"}, 72'(evt_err_cnt), 72'(exp_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    exp_out.delete();
    exp_pld.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    #2;
    check({name, "_out_wr"}, 72'(out_wr), 72'(0));
    check({name, "_pld_empty"}, 72'(pld_fifo_empty), 72'(1));
    check({name, "_in_rdy"}, 72'(in_rdy), 72'(1));
    check({name, "_pkt_cnt"}, 72'(evt_pkt_cnt), 72'(0));
    check({name, "_err_cnt"}, 72'(evt_err_cnt), 72'(0));
  endtask

  initial begin
    word_t w;
    int    k;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");

    // Plain 10-word IPv4 packet passes through.
    rdy_mode = 0; pop_mode = 1;
    send_pkt(10, 1'b0, '0, 8'h00);
    wait_drain("drain_plain", 1'b1, 500);
    check("plain_pld_empty", 72'(pld_fifo_empty), 72'(1));
    check_cnts("plain");

    // Good event packet, payload 1..8, last ctrl 0x01.
    send_pkt(15, 1'b1, 64'h1, 8'h01);
    wait_drain("drain_evt", 1'b1, 500);
    check_cnts("evt");

    // Mixed traffic with 50% backpressure.
    rdy_mode = 1;
    send_pkt(10, 1'b0, '0, 8'h00);
    send_pkt(15, 1'b1, 64'h100, 8'h00);
    send_pkt(12, 1'b0, '0, 8'h00);
    wait_drain("drain_mixed", 1'b1, 1000);
    check_cnts("mixed");

    // Payload FIFO nearly full, slow consumer: input must stall without losing words.
    rdy_mode = 0; pop_mode = 0;
    for (int i = 0; i < 4; i++) send_pkt(15, 1'b1, 64'h1000 * (i + 1), 8'h00);
    wait_drain("drain_prefill_tx", 1'b0, 1000);
    pop_once = 1'b1;
    k = 0;
    while (pop_once && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("prefill_pop_once", 72'(pop_once), 72'(0));
    saw_stall = 1'b0;
    pop_mode = 2;
    send_pkt(15, 1'b1, 64'h9000, 8'h00);
    send_pkt(10, 1'b0, '0, 8'h00);
    wait_drain("drain_stall", 1'b1, 2000);
    check("stall_in_rdy_dropped", 72'(saw_stall), 72'(1));
    check_cnts("stall");

    // Truncated payload, then over-long payload.
    pop_mode = 1; rdy_mode = 1;
    do_reset();
    send_pkt(11, 1'b1, 64'hA0, 8'h00);
    send_pkt(17, 1'b1, 64'hB0, 8'h00);
    wait_drain("drain_malformed", 1'b1, 1000);
    check_cnts("malformed");
    check("malformed_err_is_2", 72'(evt_err_cnt), 72'(2));

    // Random traffic.
    pop_mode = 3;
    for (int i = 0; i < 25; i++) begin
      k = $urandom_range(0, 3);
      case (k)
        0:       send_pkt($urandom_range(2, 20), 1'b0, '0, 8'h00);
        1:       send_pkt(15, 1'b1, {$urandom, $urandom}, 8'h00);
        2:       send_pkt($urandom_range(4, 14), 1'b1, {$urandom, $urandom}, 8'h00);
        default: send_pkt($urandom_range(16, 20), 1'b1, {$urandom, $urandom}, 8'h00);
      endcase
    end
    wait_drain("drain_random", 1'b1, 20000);
    check_cnts("random");

    // Short packet, then reset in the header of an event packet.
    rdy_mode = 0; pop_mode = 1;
    do_reset();
    send_pkt(2, 1'b0, '0, 8'h00);
    wait_drain("drain_short", 1'b1, 500);
    for (int i = 0; i < 5; i++) begin
      w = {(i == 0) ? 8'hFF : 8'h00, $urandom, $urandom};
      if (i == 2) w[31:16] = 16'h88B5;
      tx_q.push_back(w);
    end
    wait_drain("drain_partial_tx", 1'b0, 500);
    do_reset();
    check_idle_outputs("midpkt_reset");
    repeat (20) @(negedge clk);
    send_pkt(6, 1'b0, '0, 8'h00);
    wait_drain("drain_after_reset", 1'b1, 500);
    check_cnts("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
